// File: rtl/operand_fetch_pkg.sv
// Shared opcode constants, FSM encoding and operand-usage helpers for the
// fetch/writeback pair.
package operand_fetch_pkg;

  localparam logic [3:0] OP_LOD  = 4'b0001;
  localparam logic [3:0] OP_STO  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LODI = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;

  // Encoding is visible on the dbg_state port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic reads_a(input logic [3:0] op);
    return op inside {OP_STO, OP_ADD, OP_ADDI, OP_NAND};
  endfunction

  function automatic logic reads_b(input logic [3:0] op);
    return op inside {OP_LOD, OP_STO, OP_ADD, OP_NAND};
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    return op inside {OP_LOD, OP_ADD, OP_ADDI, OP_LODI, OP_NAND};
  endfunction

  function automatic logic [7:0] reg_at(input logic [127:0] regs, input logic [3:0] idx);
    return regs[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// 16-entry in-flight destination tracker. Lookups see the state after this
// cycle's retire, so a waiter can leave on the same edge the retire lands.
module operand_fetch_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [3:0]  set_idx,
  input  logic        clr_en,
  input  logic [3:0]  clr_idx,
  input  logic [3:0]  rd_a_idx,
  input  logic [3:0]  rd_b_idx,
  output logic        rd_a_pend,
  output logic        rd_b_pend,
  output logic [15:0] bits
);

  logic [15:0] sb;
  logic [15:0] set_mask;
  logic [15:0] clr_mask;
  logic [15:0] after_clr;

  always_comb begin
    set_mask  = set_en ? (16'h0001 << set_idx) : 16'h0000;
    clr_mask  = clr_en ? (16'h0001 << clr_idx) : 16'h0000;
    after_clr = sb & ~clr_mask;
    rd_a_pend = after_clr[rd_a_idx];
    rd_b_pend = after_clr[rd_b_idx];
  end

  // OR-ing the set after the clear makes a same-edge set win.
  always_ff @(posedge clk) begin
    if (rst) sb <= 16'h0000;
    else     sb <= after_clr | set_mask;
  end

  assign bits = sb;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: latches one decoded instruction, waits out read-after-write
// hazards against the scoreboard, then presents operand values for one cycle.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [3:0]   op,
  input  logic [3:0]   reg_a,
  input  logic [3:0]   reg_b,
  input  logic [7:0]   imm,
  input  logic [127:0] regs,
  input  logic         wb_ready,
  input  logic [3:0]   wb_op,
  input  logic [3:0]   wb_addr,
  output logic         ready,
  output logic         stall,
  output logic [3:0]   op_out,
  output logic [3:0]   dst_out,
  output logic [7:0]   val_a,
  output logic [7:0]   val_b,
  output logic [1:0]   dbg_state,
  output logic [15:0]  dbg_scoreboard
);

  // valid/ready: en is taken only in IDLE; ready pulses for the single DONE
  // cycle and the caller must not raise en again before that pulse.
  state_t     state;
  logic [3:0] op_q, a_q, b_q;
  logic [7:0] imm_q;

  logic [3:0] cur_op, cur_a, cur_b;
  logic [7:0] cur_imm;
  logic       pend_a, pend_b, hazard;
  logic       enter_done;
  logic [7:0] sel_a, sel_b;

  // In IDLE the incoming instruction is checked directly; in WAIT the latched copy.
  always_comb begin
    cur_op  = (state == ST_IDLE) ? op    : op_q;
    cur_a   = (state == ST_IDLE) ? reg_a : a_q;
    cur_b   = (state == ST_IDLE) ? reg_b : b_q;
    cur_imm = (state == ST_IDLE) ? imm   : imm_q;
    hazard  = (reads_a(cur_op) && pend_a) || (reads_b(cur_op) && pend_b);
    enter_done = !hazard && ((state == ST_IDLE && en) || state == ST_WAIT);

    if (cur_op == OP_LODI)     sel_a = cur_imm;
    else if (reads_a(cur_op))  sel_a = reg_at(regs, cur_a);
    else                       sel_a = 8'h00;

    if (cur_op == OP_ADDI)     sel_b = cur_imm;
    else if (reads_b(cur_op))  sel_b = reg_at(regs, cur_b);
    else                       sel_b = 8'h00;
  end

  operand_fetch_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (enter_done && writes_reg(cur_op)),
    .set_idx   (cur_a),
    .clr_en    (wb_ready && writes_reg(wb_op)),
    .clr_idx   (wb_addr),
    .rd_a_idx  (cur_a),
    .rd_b_idx  (cur_b),
    .rd_a_pend (pend_a),
    .rd_b_pend (pend_b),
    .bits      (dbg_scoreboard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= 4'h0;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      imm_q   <= 8'h00;
      ready   <= 1'b0;
      stall   <= 1'b0;
      op_out  <= 4'h0;
      dst_out <= 4'h0;
      val_a   <= 8'h00;
      val_b   <= 8'h00;
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            op_q    <= op;
            a_q     <= reg_a;
            b_q     <= reg_b;
            imm_q   <= imm;
            op_out  <= op;
            dst_out <= reg_a;
            if (hazard) begin
              state <= ST_WAIT;
              stall <= 1'b1;
            end else begin
              state <= ST_DONE;
              ready <= 1'b1;
              val_a <= sel_a;
              val_b <= sel_b;
            end
          end
        end
        ST_WAIT: begin
          if (!hazard) begin
            state <= ST_DONE;
            stall <= 1'b0;
            ready <= 1'b1;
            val_a <= sel_a;
            val_b <= sel_b;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus a randomized run against a
// register-level model of pending destinations and operand selection.
module tb_operand_fetch;

  localparam logic [3:0] LOD = 4'h1, STO = 4'h2, ADD = 4'h3, ADDI = 4'h4, LODI = 4'h5, NAND = 4'h6;
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [3:0]   op = 4'h0, reg_a = 4'h0, reg_b = 4'h0;
  logic [7:0]   imm = 8'h00;
  logic [127:0] regs;
  logic         wb_ready = 1'b0;
  logic [3:0]   wb_op = 4'h0, wb_addr = 4'h0;
  logic         ready, stall;
  logic [3:0]   op_out, dst_out;
  logic [7:0]   val_a, val_b;
  logic [1:0]   dbg_state;
  logic [15:0]  dbg_scoreboard;

  logic [7:0]   rf[16];
  logic [15:0]  model_sb;
  int           checks = 0;
  int           errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always_comb begin
    regs = '0;
    for (int i = 0; i < 16; i++) regs[8*i +: 8] = rf[i];
  end

  operand_fetch dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .reg_a(reg_a), .reg_b(reg_b), .imm(imm),
    .regs(regs), .wb_ready(wb_ready), .wb_op(wb_op), .wb_addr(wb_addr),
    .ready(ready), .stall(stall), .op_out(op_out), .dst_out(dst_out),
    .val_a(val_a), .val_b(val_b), .dbg_state(dbg_state), .dbg_scoreboard(dbg_scoreboard)
  );

  // ---------------- reference model ----------------
  function automatic logic m_reads_a(input logic [3:0] o);
    return (o == STO) || (o == ADD) || (o == ADDI) || (o == NAND);
  endfunction
  function automatic logic m_reads_b(input logic [3:0] o);
    return (o == LOD) || (o == STO) || (o == ADD) || (o == NAND);
  endfunction
  function automatic logic m_writes(input logic [3:0] o);
    return (o >= LOD) && (o <= NAND) && (o != STO);
  endfunction
  function automatic logic [7:0] m_val_a(input logic [3:0] o, input logic [3:0] a, input logic [7:0] i);
    if (o == LODI) return i;
    return m_reads_a(o) ? rf[a] : 8'h00;
  endfunction
  function automatic logic [7:0] m_val_b(input logic [3:0] o, input logic [3:0] b, input logic [7:0] i);
    if (o == ADDI) return i;
    return m_reads_b(o) ? rf[b] : 8'h00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; wb_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_sb = 16'h0000;
  endtask

  task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b, input logic [7:0] i);
    op = o; reg_a = a; reg_b = b; imm = i; en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic retire(input logic [3:0] o, input logic [3:0] addr, input logic [7:0] nv);
    wb_ready = 1'b1; wb_op = o; wb_addr = addr; rf[addr] = nv;
    tick();
    wb_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if ({op_out, dst_out, val_a, val_b} !== 24'h0) begin errors++; $display("FAIL reset_outs got %h exp 0", {op_out, dst_out, val_a, val_b}); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE); end
    checks++; if (dbg_scoreboard !== 16'h0) begin errors++; $display("FAIL reset_sb got %h exp 0", dbg_scoreboard); end
  endtask

  task automatic test_basic_add();
    do_reset();
    rf[1] = 8'h05; rf[2] = 8'h0A;
    issue(ADD, 4'd1, 4'd2, 8'h00);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b exp 1", ready); end
    checks++; if (val_a !== 8'h05 || val_b !== 8'h0A) begin errors++; $display("FAIL add_vals got %h/%h exp 05/0a", val_a, val_b); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL add_stall got %b exp 0", stall); end
    checks++; if (op_out !== ADD || dst_out !== 4'd1) begin errors++; $display("FAIL add_latch got %h/%h exp 3/1", op_out, dst_out); end
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL add_pulse got %b exp 0", ready); end
    checks++; if (dbg_scoreboard !== 16'h0002) begin errors++; $display("FAIL add_sb got %h exp 0002", dbg_scoreboard); end
  endtask

  task automatic test_raw_stall();
    do_reset();
    rf[4] = 8'h21;
    issue(LODI, 4'd3, 4'd0, 8'h7F);
    checks++; if (ready !== 1'b1 || val_a !== 8'h7F) begin errors++; $display("FAIL lodi_done got %b/%h exp 1/7f", ready, val_a); end
    tick();
    issue(ADD, 4'd4, 4'd3, 8'h00);
    for (int c = 0; c < 5; c++) begin
      checks++; if (stall !== 1'b1 || ready !== 1'b0 || dbg_state !== S_WAIT) begin
        errors++; $display("FAIL raw_hold cycle %0d got stall=%b ready=%b st=%0d exp 1/0/%0d", c, stall, ready, dbg_state, S_WAIT);
      end
      tick();
    end
    retire(LODI, 4'd3, 8'h7F);
    checks++; if (ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL raw_release got ready=%b stall=%b exp 1/0", ready, stall); end
    checks++; if (val_a !== 8'h21 || val_b !== 8'h7F) begin errors++; $display("FAIL raw_vals got %h/%h exp 21/7f", val_a, val_b); end
    tick();
    checks++; if (dbg_scoreboard !== 16'h0010) begin errors++; $display("FAIL raw_sb got %h exp 0010", dbg_scoreboard); end
  endtask

  task automatic test_addi_ignores_b();
    do_reset();
    rf[5] = 8'h33;
    issue(LODI, 4'd6, 4'd0, 8'h01);
    tick();
    issue(ADDI, 4'd5, 4'd6, 8'h11);
    checks++; if (ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL addi_nostall got ready=%b stall=%b exp 1/0", ready, stall); end
    checks++; if (val_a !== 8'h33 || val_b !== 8'h11) begin errors++; $display("FAIL addi_vals got %h/%h exp 33/11", val_a, val_b); end
    checks++; if (dbg_scoreboard !== 16'h0060) begin errors++; $display("FAIL addi_sb got %h exp 0060", dbg_scoreboard); end
    tick();
  endtask

  task automatic test_set_wins();
    do_reset();
    issue(LODI, 4'd2, 4'd0, 8'h44);
    tick();
    // Retire of reg 2 lands on the same edge the new LODI to reg 2 enters DONE.
    op = LODI; reg_a = 4'd2; reg_b = 4'd0; imm = 8'h55; en = 1'b1;
    wb_ready = 1'b1; wb_op = ADD; wb_addr = 4'd2;
    tick();
    en = 1'b0; wb_ready = 1'b0;
    checks++; if (dbg_scoreboard !== 16'h0004) begin errors++; $display("FAIL setwin_sb got %h exp 0004", dbg_scoreboard); end
    tick();
    issue(ADD, 4'd7, 4'd2, 8'h00);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL setwin_stall got %b exp 1", stall); end
    retire(STO, 4'd2, rf[2]);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nonwrite_retire got stall=%b exp 1", stall); end
    retire(ADD, 4'd2, 8'h66);
    checks++; if (ready !== 1'b1 || val_b !== 8'h66) begin errors++; $display("FAIL setwin_release got %b/%h exp 1/66", ready, val_b); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    issue(LODI, 4'd8, 4'd0, 8'h01);
    tick();
    issue(ADD, 4'd9, 4'd8, 8'h00);
    tick();
    checks++; if (dbg_state !== S_WAIT) begin errors++; $display("FAIL rstwait_pre got %0d exp %0d", dbg_state, S_WAIT); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (dbg_state !== S_IDLE || stall !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL rstwait_ctl got st=%0d stall=%b ready=%b exp 0/0/0", dbg_state, stall, ready);
    end
    checks++; if (dbg_scoreboard !== 16'h0 || op_out !== 4'h0) begin errors++; $display("FAIL rstwait_clear got sb=%h op=%h exp 0/0", dbg_scoreboard, op_out); end
    model_sb = 16'h0;
  endtask

  task automatic test_no_write_ops();
    do_reset();
    rf[1] = 8'hA1; rf[2] = 8'hB2;
    issue(STO, 4'd1, 4'd2, 8'h99);
    checks++; if (ready !== 1'b1 || val_a !== 8'hA1 || val_b !== 8'hB2) begin errors++; $display("FAIL sto got %b/%h/%h exp 1/a1/b2", ready, val_a, val_b); end
    tick();
    checks++; if (dbg_scoreboard !== 16'h0) begin errors++; $display("FAIL sto_sb got %h exp 0", dbg_scoreboard); end
    issue(4'hF, 4'd3, 4'd4, 8'h77);
    checks++; if (ready !== 1'b1 || val_a !== 8'h00 || val_b !== 8'h00) begin errors++; $display("FAIL unk got %b/%h/%h exp 1/00/00", ready, val_a, val_b); end
    tick();
    checks++; if (dbg_scoreboard !== 16'h0) begin errors++; $display("FAIL unk_sb got %h exp 0", dbg_scoreboard); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [3:0] op_tab[8];
    logic [3:0] srcs[$];
    logic [3:0] o, a, b;
    logic [7:0] i;
    op_tab = '{LOD, STO, ADD, ADDI, LODI, NAND, 4'h0, 4'hF};
    do_reset();
    for (int r = 0; r < 16; r++) rf[r] = 8'($urandom);
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < 16; r++) begin
        if (model_sb[r] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 3) == 0) retire(STO, 4'(r), rf[r]);
          else begin retire(ADD, 4'(r), 8'($urandom)); model_sb[r] = 1'b0; end
        end
      end
      o = op_tab[$urandom_range(0, 7)];
      a = 4'($urandom_range(0, 15));
      b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
      i = 8'($urandom);
      srcs.delete();
      if (m_reads_a(o) && model_sb[a]) srcs.push_back(a);
      if (m_reads_b(o) && model_sb[b] && !(m_reads_a(o) && a == b)) srcs.push_back(b);
      issue(o, a, b, i);
      if (srcs.size() == 0) begin
        checks++; if (ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL rnd_fast it %0d got ready=%b stall=%b exp 1/0", it, ready, stall); end
      end else begin
        checks++; if (stall !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL rnd_stall it %0d got stall=%b ready=%b exp 1/0", it, stall, ready); end
        repeat ($urandom_range(0, 2)) tick();
        for (int s = 0; s < srcs.size(); s++) begin
          retire(ADD, srcs[s], 8'($urandom));
          model_sb[srcs[s]] = 1'b0;
          checks++; if (ready !== (s == srcs.size() - 1)) begin
            errors++; $display("FAIL rnd_release it %0d src %0d got ready=%b exp %b", it, s, ready, s == srcs.size() - 1);
          end
        end
      end
      exp_q.push_back(m_val_a(o, a, i));
      exp_q.push_back(m_val_b(o, b, i));
      if (m_writes(o)) model_sb[a] = 1'b1;
      checks++; if (val_a !== exp_q[0] || val_b !== exp_q[1]) begin
        errors++; $display("FAIL rnd_vals it %0d op %h got %h/%h exp %h/%h", it, o, val_a, val_b, exp_q[0], exp_q[1]);
      end
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      checks++; if (op_out !== o || dst_out !== a) begin errors++; $display("FAIL rnd_latch it %0d got %h/%h exp %h/%h", it, op_out, dst_out, o, a); end
      tick();
      checks++; if (ready !== 1'b0 || dbg_scoreboard !== model_sb) begin
        errors++; $display("FAIL rnd_sb it %0d got ready=%b sb=%h exp 0/%h", it, ready, dbg_scoreboard, model_sb);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int r = 0; r < 16; r++) rf[r] = 8'h00;
    model_sb = 16'h0;
    test_reset();
    test_basic_add();
    test_raw_stall();
    test_addi_ignores_b();
    test_set_wins();
    test_reset_in_wait();
    test_no_write_ops();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
